// File: rtl/asip_pkg.sv
// Shared defaults and types for the ASIP data-memory controller.
package asip_pkg;

    localparam int DEF_WIDTH  = 17;
    localparam int DEF_ADDR_W = 17;
    localparam int DEF_MMIO_BASE = (1 << DEF_ADDR_W) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // The I/O register sits at the top of the address space for any address width.
    function automatic int default_mmio_base(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/asip_dmem_ram.sv
// Single-port data RAM: synchronous write with one enable, combinational read.
module asip_dmem_ram #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/asip_dmem_ctrl.sv
// Data-memory controller: fixed-latency RAM/MMIO access behind a stall handshake.
// Define ASIP_DMEM_MMIO_EN to enable the io_in/io_out register at MMIO_BASE.
module asip_dmem_ctrl
    import asip_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int MMIO_BASE   = default_mmio_base(ADDR_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              stall,
    input  logic [WIDTH-1:0]  io_in,
    output logic [WIDTH-1:0]  io_out,
    output logic              io_wr_strobe,
    output logic              err
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] MMIO_ADDR = ADDR_W'(MMIO_BASE);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              is_write_q, is_write_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic [WIDTH-1:0]  io_out_q, io_out_d;
    logic              io_wr_strobe_q, io_wr_strobe_d;
    logic              err_q, err_d;

    logic              access;
    logic [ADDR_W-1:0] acc_addr;
    logic [WIDTH-1:0]  acc_wdata;
    logic              acc_write;
    logic              in_ram;
    logic              in_mmio;
    logic              ram_we;
    logic [WIDTH-1:0]  ram_rdata;

    // With a single wait cycle the access happens on the accepting edge, so the
    // access path must see the live request rather than the latched copy.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        access     = 1'b0;
        acc_addr   = addr_q;
        acc_wdata  = wdata_q;
        acc_write  = is_write_q;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    stall      = 1'b1;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    is_write_d = mem_write;
                    acc_addr   = addr;
                    acc_wdata  = wdata;
                    acc_write  = mem_write;
                    if (WAIT_CYCLES > 1) begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        access  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    access  = 1'b1;
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!reset) begin
            stall = 1'b0;
        end
    end

    assign in_ram = ({1'b0, acc_addr} < DEPTH_EXT);
`ifdef ASIP_DMEM_MMIO_EN
    assign in_mmio = !in_ram && (acc_addr == MMIO_ADDR);
`else
    assign in_mmio = 1'b0;
`endif
    assign ram_we = access && acc_write && in_ram && reset;

    always_comb begin
        rdata_d        = rdata_q;
        io_out_d       = io_out_q;
        io_wr_strobe_d = 1'b0;
        err_d          = err_q;
        if (access) begin
            if (in_ram) begin
                if (!acc_write) begin
                    rdata_d = ram_rdata;
                end
            end else if (in_mmio) begin
                if (acc_write) begin
                    io_out_d       = acc_wdata;
                    io_wr_strobe_d = 1'b1;
                end else begin
                    rdata_d = io_in;
                end
            end else begin
                err_d = 1'b1;
                if (!acc_write) begin
                    rdata_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            is_write_q     <= 1'b0;
            rdata_q        <= '0;
            io_out_q       <= '0;
            io_wr_strobe_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            is_write_q     <= is_write_d;
            rdata_q        <= rdata_d;
            io_out_q       <= io_out_d;
            io_wr_strobe_q <= io_wr_strobe_d;
            err_q          <= err_d;
        end
    end

    asip_dmem_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (acc_addr[RAM_AW-1:0]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    assign rdata = rdata_q;
    assign err   = err_q;
`ifdef ASIP_DMEM_MMIO_EN
    assign io_out       = io_out_q;
    assign io_wr_strobe = io_wr_strobe_q;
`else
    logic unused_mmio;
    assign unused_mmio  = ^{io_out_q, io_wr_strobe_q};
    assign io_out       = '0;
    assign io_wr_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_asip_dmem_ctrl.sv
// Randomized self-checking bench for asip_dmem_ctrl against an address-map reference model.
// MMIO checks follow ASIP_DMEM_MMIO_EN, matching the build of the design.
module tb_asip_dmem_ctrl;

    localparam int WIDTH     = 17;
    localparam int ADDR_W    = 17;
    localparam int DEPTH     = 1024;
    localparam int WAIT      = 2;
    localparam int MMIO_BASE = (1 << ADDR_W) - 1;
    localparam int MAX_WAIT  = 20;

    logic clk = 1'b0;
    logic reset;
    logic mem_read, mem_write;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata, io_in;
    logic [WIDTH-1:0]  rdata, io_out;
    logic stall, io_wr_strobe, err;

    logic mr1, mw1, mr3, mw3;
    logic [WIDTH-1:0] rdata1, rdata3, io_out1, io_out3;
    logic stall1, stall3, strobe1, strobe3, err1, err3;

    logic [WIDTH-1:0] ref_mem [int];
    logic [WIDTH-1:0] ref_rdata;
    logic [WIDTH-1:0] ref_io_out;
    logic             ref_err;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    asip_dmem_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .io_in(io_in),
        .io_out(io_out), .io_wr_strobe(io_wr_strobe), .err(err)
    );

    asip_dmem_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset(reset), .mem_read(mr1), .mem_write(mw1),
        .addr(addr), .wdata(wdata), .rdata(rdata1), .stall(stall1), .io_in(io_in),
        .io_out(io_out1), .io_wr_strobe(strobe1), .err(err1)
    );

    asip_dmem_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .reset(reset), .mem_read(mr3), .mem_write(mw3),
        .addr(addr), .wdata(wdata), .rdata(rdata3), .stall(stall3), .io_in(io_in),
        .io_out(io_out3), .io_wr_strobe(strobe3), .err(err3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference address map: RAM below DEPTH, optional I/O register, everything else errors.
    task automatic model_access(input bit w, input int a, input logic [WIDTH-1:0] d,
                                input logic [WIDTH-1:0] in_val, output bit strobe_exp);
        strobe_exp = 1'b0;
        if (a < DEPTH) begin
            if (w) ref_mem[a] = d;
            else   ref_rdata = ref_mem.exists(a) ? ref_mem[a] : 'x;
        end
`ifdef ASIP_DMEM_MMIO_EN
        else if (a == MMIO_BASE) begin
            if (w) begin
                ref_io_out = d;
                strobe_exp = 1'b1;
            end else begin
                ref_rdata = in_val;
            end
        end
`endif
        else begin
            ref_err = 1'b1;
            if (!w) ref_rdata = '0;
        end
    endtask

    // One full transaction on the WAIT=2 instance; in_done means it is issued during the previous DONE cycle.
    task automatic applyStimulus(input bit w, input int a, input logic [WIDTH-1:0] d,
                                 input logic [WIDTH-1:0] io_val, input bit in_done);
        int n;
        bit strobe_exp;
        mem_write = w;
        mem_read  = w ? ($urandom_range(0, 3) == 0) : 1'b1;
        addr      = ADDR_W'(a);
        wdata     = d;
        io_in     = io_val;
        #1;
        if (in_done) begin
            checkOutput("done_ignores_req", 32'(stall), 32'(0));
            @(negedge clk);
            #1;
        end
        model_access(w, a, d, io_val, strobe_exp);
        n = 0;
        while (stall && n < MAX_WAIT) begin
            n++;
            @(negedge clk);
            addr  = ADDR_W'($urandom);
            wdata = WIDTH'($urandom);
            #1;
        end
        checkOutput("stall_cycles", 32'(n), 32'(WAIT));
        checkOutput("rdata", 32'(rdata), 32'(ref_rdata));
        checkOutput("err", 32'(err), 32'(ref_err));
        checkOutput("io_out", 32'(io_out), 32'(ref_io_out));
        checkOutput("io_wr_strobe", 32'(io_wr_strobe), 32'(strobe_exp));
    endtask

    task automatic idle_gap();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("idle_stall", 32'(stall), 32'(0));
        checkOutput("idle_strobe", 32'(io_wr_strobe), 32'(0));
        checkOutput("idle_rdata_hold", 32'(rdata), 32'(ref_rdata));
    endtask

    task automatic aux_access(input int which, input bit w, input int a, input logic [WIDTH-1:0] d);
        int n;
        string tag;
        if (which == 1) begin
            mr1 = !w;
            mw1 = w;
        end else begin
            mr3 = !w;
            mw3 = w;
        end
        addr  = ADDR_W'(a);
        wdata = d;
        #1;
        n = 0;
        while (((which == 1) ? stall1 : stall3) && n < MAX_WAIT) begin
            n++;
            @(negedge clk);
            #1;
        end
        tag = $sformatf("stall_cycles_w%0d", which);
        checkOutput(tag, 32'(n), 32'(which));
        if (!w) begin
            tag = $sformatf("rdata_w%0d", which);
            checkOutput(tag, 32'((which == 1) ? rdata1 : rdata3), 32'(d));
        end
        mr1 = 1'b0; mw1 = 1'b0; mr3 = 1'b0; mw3 = 1'b0;
        @(negedge clk);
        #1;
    endtask

    function automatic int pick_addr();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel <= 5) return int'($urandom_range(0, 7));
        if (sel == 6) return DEPTH - 1;
        if (sel == 7) return DEPTH + int'($urandom_range(0, 3));
        if (sel == 8) return MMIO_BASE;
        return int'($urandom_range(DEPTH, MMIO_BASE - 1));
    endfunction

    initial begin
        bit w;
        bit b2b;
        int a;
        int pre_addrs [9] = '{0, 1, 2, 3, 4, 5, 6, 7, DEPTH - 1};

        reset = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
        mr1 = 1'b0; mw1 = 1'b0; mr3 = 1'b0; mw3 = 1'b0;
        addr = '0; wdata = '0; io_in = '0;
        ref_rdata = '0; ref_io_out = '0; ref_err = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_stall", 32'(stall), 32'(0));
        checkOutput("reset_rdata", 32'(rdata), 32'(0));
        checkOutput("reset_err", 32'(err), 32'(0));
        checkOutput("reset_io_out", 32'(io_out), 32'(0));
        checkOutput("reset_strobe", 32'(io_wr_strobe), 32'(0));
        mem_read = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        #1;

        foreach (pre_addrs[i]) begin
            applyStimulus(1'b1, pre_addrs[i], WIDTH'($urandom), '0, 1'b0);
            idle_gap();
        end

        applyStimulus(1'b1, 5, 17'h1ABCD, '0, 1'b0);
        idle_gap();
        applyStimulus(1'b0, 5, '0, '0, 1'b0);
        idle_gap();

        applyStimulus(1'b1, DEPTH, 17'h1FFFF, '0, 1'b0);
        idle_gap();
        applyStimulus(1'b0, 0, '0, '0, 1'b0);
        idle_gap();
        applyStimulus(1'b0, DEPTH, '0, '0, 1'b0);
        idle_gap();

`ifdef ASIP_DMEM_MMIO_EN
        applyStimulus(1'b1, MMIO_BASE, 17'h000F0, '0, 1'b0);
        idle_gap();
        applyStimulus(1'b0, MMIO_BASE, '0, 17'h01234, 1'b0);
        idle_gap();
`endif

        applyStimulus(1'b0, 5, '0, '0, 1'b0);
        applyStimulus(1'b1, 2, 17'h00123, '0, 1'b1);
        applyStimulus(1'b0, 2, '0, '0, 1'b1);
        idle_gap();

        b2b = 1'b0;
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom_range(0, 1));
            a = pick_addr();
            applyStimulus(w, a, WIDTH'($urandom), WIDTH'($urandom), b2b);
            b2b = ($urandom_range(0, 2) == 0);
            if (!b2b) idle_gap();
        end
        if (b2b) idle_gap();

        // Reset landing in BUSY must abort the write to address 3.
        applyStimulus(1'b1, 3, 17'h15555, '0, 1'b0);
        idle_gap();
        mem_write = 1'b1; mem_read = 1'b0; addr = ADDR_W'(3); wdata = 17'h00007;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("stall_during_reset", 32'(stall), 32'(0));
        @(negedge clk);
        mem_write = 1'b0;
        reset     = 1'b1;
        #1;
        ref_rdata = '0; ref_io_out = '0; ref_err = 1'b0;
        checkOutput("post_reset_stall", 32'(stall), 32'(0));
        checkOutput("post_reset_rdata", 32'(rdata), 32'(0));
        checkOutput("post_reset_err", 32'(err), 32'(0));
        checkOutput("post_reset_io_out", 32'(io_out), 32'(0));
        applyStimulus(1'b0, 3, '0, '0, 1'b0);
        idle_gap();

        aux_access(1, 1'b1, 9, 17'h0BEEF);
        aux_access(1, 1'b0, 9, 17'h0BEEF);
        aux_access(3, 1'b1, 9, 17'h1C0DE);
        aux_access(3, 1'b0, 9, 17'h1C0DE);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
